// File: rtl/alu_reservation_station_pkg.sv
// Shared widths, opcodes and operand record for the ALU reservation station.
// cdb_snoop is shared by dispatch capture and per-entry wakeup.
package alu_reservation_station_pkg;

    localparam int DATA_W          = 32;
    localparam int OPCODE_W        = 6;
    localparam int ROB_ID_W        = 4;
    localparam int DEFAULT_RS_SIZE = 16;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [DATA_W-1:0] ZERO = '0;

    localparam logic [OPCODE_W-1:0] NOP     = 6'd0;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 6'd1;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 6'd2;
    localparam logic [OPCODE_W-1:0] OP_AND  = 6'd3;
    localparam logic [OPCODE_W-1:0] OP_OR   = 6'd4;
    localparam logic [OPCODE_W-1:0] OP_XOR  = 6'd5;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 6'd6;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'd7;

    typedef struct packed {
        logic                rdy;
        logic [ROB_ID_W-1:0] alias_id;
        logic [DATA_W-1:0]   val;
    } operand_t;

    // The ALU bus wins if both buses carry the waited-for alias.
    function automatic operand_t cdb_snoop(
        input operand_t            op,
        input logic                alu_v,
        input logic [ROB_ID_W-1:0] alu_a,
        input logic [DATA_W-1:0]   alu_d,
        input logic                lsb_v,
        input logic [ROB_ID_W-1:0] lsb_a,
        input logic [DATA_W-1:0]   lsb_d
    );
        operand_t res;
        res = op;
        if (!op.rdy) begin
            if (alu_v && (alu_a == op.alias_id)) begin
                res.rdy = TRUE;
                res.val = alu_d;
            end else if (lsb_v && (lsb_a == op.alias_id)) begin
                res.rdy = TRUE;
                res.val = lsb_d;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_reservation_station_rs_pick.sv
// Lowest-index priority encoder: reports whether any request is set and
// the index of the lowest one.
module rs_pick #(
    parameter int N     = 16,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// Integer/branch reservation station: buffers dispatched ops, snoops both CDBs
// for operands, and issues the lowest-index ready entry to the ALU each cycle.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int RS_SIZE = DEFAULT_RS_SIZE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rdy,
    input  logic                rollback,
    input  logic                dsp_valid,
    input  logic [OPCODE_W-1:0] dsp_optype,
    input  logic [ROB_ID_W-1:0] dsp_rd_alias,
    input  logic [DATA_W-1:0]   dsp_pc,
    input  logic [DATA_W-1:0]   dsp_imm,
    input  logic                dsp_rs1_rdy,
    input  logic                dsp_rs2_rdy,
    input  logic [DATA_W-1:0]   dsp_rs1_val,
    input  logic [DATA_W-1:0]   dsp_rs2_val,
    input  logic [ROB_ID_W-1:0] dsp_rs1_alias,
    input  logic [ROB_ID_W-1:0] dsp_rs2_alias,
    input  logic                alu_cdb_valid,
    input  logic [ROB_ID_W-1:0] alu_cdb_alias,
    input  logic [DATA_W-1:0]   alu_cdb_val,
    input  logic                lsb_cdb_valid,
    input  logic [ROB_ID_W-1:0] lsb_cdb_alias,
    input  logic [DATA_W-1:0]   lsb_cdb_val,
    output logic                full,
    output logic [OPCODE_W-1:0] alu_optype,
    output logic [ROB_ID_W-1:0] alu_rd_alias,
    output logic [DATA_W-1:0]   alu_pc,
    output logic [DATA_W-1:0]   alu_rs1,
    output logic [DATA_W-1:0]   alu_rs2,
    output logic [DATA_W-1:0]   alu_imm
);

    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]  busy;
    logic [OPCODE_W-1:0] ent_optype   [RS_SIZE];
    logic [ROB_ID_W-1:0] ent_rd_alias [RS_SIZE];
    logic [DATA_W-1:0]   ent_pc       [RS_SIZE];
    logic [DATA_W-1:0]   ent_imm      [RS_SIZE];
    operand_t            ent_rs1      [RS_SIZE];
    operand_t            ent_rs2      [RS_SIZE];

    logic [RS_SIZE-1:0]  free_vec;
    logic [RS_SIZE-1:0]  ready_vec;
    logic                free_valid;
    logic                sel_valid;
    logic [IDX_W-1:0]    free_idx;
    logic [IDX_W-1:0]    sel_idx;
    logic                do_dsp;
    logic                do_issue;
    operand_t            dsp_rs1_op;
    operand_t            dsp_rs2_op;

    // Eligibility looks only at registered operand state, so a wakeup this
    // cycle becomes issuable on the following edge.
    always_comb begin
        free_vec  = ~busy;
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            ready_vec[i] = busy[i] & ent_rs1[i].rdy & ent_rs2[i].rdy;
        end
    end

    assign full = &busy;

    rs_pick #(.N(RS_SIZE)) u_free_pick (
        .req   (free_vec),
        .valid (free_valid),
        .idx   (free_idx)
    );

    rs_pick #(.N(RS_SIZE)) u_ready_pick (
        .req   (ready_vec),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    assign do_dsp   = dsp_valid & rdy & ~rollback & ~full & free_valid;
    assign do_issue = rdy & ~rollback & sel_valid;

    always_comb begin
        dsp_rs1_op = cdb_snoop('{rdy: dsp_rs1_rdy, alias_id: dsp_rs1_alias, val: dsp_rs1_val},
                               alu_cdb_valid, alu_cdb_alias, alu_cdb_val,
                               lsb_cdb_valid, lsb_cdb_alias, lsb_cdb_val);
        dsp_rs2_op = cdb_snoop('{rdy: dsp_rs2_rdy, alias_id: dsp_rs2_alias, val: dsp_rs2_val},
                               alu_cdb_valid, alu_cdb_alias, alu_cdb_val,
                               lsb_cdb_valid, lsb_cdb_alias, lsb_cdb_val);
    end

    // Occupancy: the only entry state that needs a reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (rdy) begin
            if (rollback) begin
                busy <= '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (do_issue && (sel_idx == IDX_W'(i))) begin
                        busy[i] <= FALSE;
                    end else if (do_dsp && (free_idx == IDX_W'(i))) begin
                        busy[i] <= TRUE;
                    end
                end
            end
        end
    end

    // Entry payload and operand wakeup; contents of non-busy entries are don't-care.
    always_ff @(posedge clk) begin
        if (rdy && !rollback) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (do_dsp && (free_idx == IDX_W'(i))) begin
                    ent_optype[i]   <= dsp_optype;
                    ent_rd_alias[i] <= dsp_rd_alias;
                    ent_pc[i]       <= dsp_pc;
                    ent_imm[i]      <= dsp_imm;
                    ent_rs1[i]      <= dsp_rs1_op;
                    ent_rs2[i]      <= dsp_rs2_op;
                end else begin
                    ent_rs1[i] <= cdb_snoop(ent_rs1[i],
                                            alu_cdb_valid, alu_cdb_alias, alu_cdb_val,
                                            lsb_cdb_valid, lsb_cdb_alias, lsb_cdb_val);
                    ent_rs2[i] <= cdb_snoop(ent_rs2[i],
                                            alu_cdb_valid, alu_cdb_alias, alu_cdb_val,
                                            lsb_cdb_valid, lsb_cdb_alias, lsb_cdb_val);
                end
            end
        end
    end

    // Issue register: loads NOP whenever nothing issues so the ALU never
    // sees the same instruction on two consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_optype   <= NOP;
            alu_rd_alias <= '0;
            alu_pc       <= ZERO;
            alu_rs1      <= ZERO;
            alu_rs2      <= ZERO;
            alu_imm      <= ZERO;
        end else if (do_issue) begin
            alu_optype   <= ent_optype[sel_idx];
            alu_rd_alias <= ent_rd_alias[sel_idx];
            alu_pc       <= ent_pc[sel_idx];
            alu_rs1      <= ent_rs1[sel_idx].val;
            alu_rs2      <= ent_rs2[sel_idx].val;
            alu_imm      <= ent_imm[sel_idx];
        end else begin
            alu_optype   <= NOP;
            alu_rd_alias <= '0;
            alu_pc       <= ZERO;
            alu_rs1      <= ZERO;
            alu_rs2      <= ZERO;
            alu_imm      <= ZERO;
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: a vector table for single
// dispatch/issue cases plus hand-written multi-cycle sequences.
module tb_alu_reservation_station;
    import alu_reservation_station_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                rdy;
    logic                rollback;
    logic                dsp_valid;
    logic [OPCODE_W-1:0] dsp_optype;
    logic [ROB_ID_W-1:0] dsp_rd_alias;
    logic [DATA_W-1:0]   dsp_pc;
    logic [DATA_W-1:0]   dsp_imm;
    logic                dsp_rs1_rdy;
    logic                dsp_rs2_rdy;
    logic [DATA_W-1:0]   dsp_rs1_val;
    logic [DATA_W-1:0]   dsp_rs2_val;
    logic [ROB_ID_W-1:0] dsp_rs1_alias;
    logic [ROB_ID_W-1:0] dsp_rs2_alias;
    logic                alu_cdb_valid;
    logic [ROB_ID_W-1:0] alu_cdb_alias;
    logic [DATA_W-1:0]   alu_cdb_val;
    logic                lsb_cdb_valid;
    logic [ROB_ID_W-1:0] lsb_cdb_alias;
    logic [DATA_W-1:0]   lsb_cdb_val;
    logic                full;
    logic [OPCODE_W-1:0] alu_optype;
    logic [ROB_ID_W-1:0] alu_rd_alias;
    logic [DATA_W-1:0]   alu_pc;
    logic [DATA_W-1:0]   alu_rs1;
    logic [DATA_W-1:0]   alu_rs2;
    logic [DATA_W-1:0]   alu_imm;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [5:0]  op;
        logic [3:0]  rd;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        r1_rdy;
        logic [31:0] r1_val;
        logic [3:0]  r1_al;
        logic        r2_rdy;
        logic [31:0] r2_val;
        logic [3:0]  r2_al;
        logic        acv;
        logic [3:0]  aca;
        logic [31:0] acd;
        logic        lcv;
        logic [3:0]  lca;
        logic [31:0] lcd;
        logic [31:0] exp_rs1;
        logic [31:0] exp_rs2;
    } vec_t;

    vec_t vecs [6];

    alu_reservation_station #(.RS_SIZE(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rdy           (rdy),
        .rollback      (rollback),
        .dsp_valid     (dsp_valid),
        .dsp_optype    (dsp_optype),
        .dsp_rd_alias  (dsp_rd_alias),
        .dsp_pc        (dsp_pc),
        .dsp_imm       (dsp_imm),
        .dsp_rs1_rdy   (dsp_rs1_rdy),
        .dsp_rs2_rdy   (dsp_rs2_rdy),
        .dsp_rs1_val   (dsp_rs1_val),
        .dsp_rs2_val   (dsp_rs2_val),
        .dsp_rs1_alias (dsp_rs1_alias),
        .dsp_rs2_alias (dsp_rs2_alias),
        .alu_cdb_valid (alu_cdb_valid),
        .alu_cdb_alias (alu_cdb_alias),
        .alu_cdb_val   (alu_cdb_val),
        .lsb_cdb_valid (lsb_cdb_valid),
        .lsb_cdb_alias (lsb_cdb_alias),
        .lsb_cdb_val   (lsb_cdb_val),
        .full          (full),
        .alu_optype    (alu_optype),
        .alu_rd_alias  (alu_rd_alias),
        .alu_pc        (alu_pc),
        .alu_rs1       (alu_rs1),
        .alu_rs2       (alu_rs2),
        .alu_imm       (alu_imm)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_nop(input string name);
        chk({name, ".optype"}, 32'(alu_optype), 32'(NOP));
        chk({name, ".pc"}, alu_pc, 32'h0);
        chk({name, ".rs1"}, alu_rs1, 32'h0);
    endtask

    task automatic idle_inputs();
        dsp_valid     = 1'b0;
        dsp_optype    = NOP;
        dsp_rd_alias  = '0;
        dsp_pc        = '0;
        dsp_imm       = '0;
        dsp_rs1_rdy   = 1'b0;
        dsp_rs2_rdy   = 1'b0;
        dsp_rs1_val   = '0;
        dsp_rs2_val   = '0;
        dsp_rs1_alias = '0;
        dsp_rs2_alias = '0;
        alu_cdb_valid = 1'b0;
        alu_cdb_alias = '0;
        alu_cdb_val   = '0;
        lsb_cdb_valid = 1'b0;
        lsb_cdb_alias = '0;
        lsb_cdb_val   = '0;
    endtask

    task automatic set_dsp(input logic [5:0] op, input logic [3:0] rd, input logic [31:0] pc,
                           input logic [31:0] imm, input logic r1r, input logic [31:0] r1v,
                           input logic [3:0] r1a, input logic r2r, input logic [31:0] r2v,
                           input logic [3:0] r2a);
        dsp_valid     = 1'b1;
        dsp_optype    = op;
        dsp_rd_alias  = rd;
        dsp_pc        = pc;
        dsp_imm       = imm;
        dsp_rs1_rdy   = r1r;
        dsp_rs1_val   = r1v;
        dsp_rs1_alias = r1a;
        dsp_rs2_rdy   = r2r;
        dsp_rs2_val   = r2v;
        dsp_rs2_alias = r2a;
    endtask

    initial begin
        vecs[0] = '{OP_ADDI, 4'd2, 32'h100, 32'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd0, 4'd0,
                    1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 32'd5, 32'd0};
        vecs[1] = '{OP_ADD, 4'd3, 32'h104, 32'd0, 1'b1, 32'h1234, 4'd0, 1'b0, 32'h0, 4'd4,
                    1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 32'hAA, 32'h1234, 32'hAA};
        vecs[2] = '{OP_SUB, 4'd5, 32'h108, 32'h11, 1'b0, 32'h0, 4'd6, 1'b1, 32'hFFFF_FFFF, 4'd0,
                    1'b1, 4'd6, 32'h77, 1'b0, 4'd0, 32'h0, 32'h77, 32'hFFFF_FFFF};
        vecs[3] = '{OP_AND, 4'd7, 32'h10C, 32'h0, 1'b0, 32'h0, 4'd8, 1'b0, 32'h0, 4'd9,
                    1'b1, 4'd8, 32'h1, 1'b1, 4'd9, 32'h2, 32'h1, 32'h2};
        vecs[4] = '{OP_OR, 4'd10, 32'h110, 32'h0, 1'b0, 32'h0, 4'd11, 1'b1, 32'h7, 4'd0,
                    1'b1, 4'd11, 32'h5, 1'b1, 4'd11, 32'h6, 32'h5, 32'h7};
        vecs[5] = '{OP_BEQ, 4'd12, 32'h114, 32'hFFFF_FFF8, 1'b1, 32'h9, 4'd12, 1'b1, 32'h9, 4'd0,
                    1'b1, 4'd12, 32'h99, 1'b0, 4'd0, 32'h0, 32'h9, 32'h9};

        idle_inputs();
        rdy      = 1'b1;
        rollback = 1'b0;
        rst_n    = 1'b0;
        repeat (2) tick();
        chk("reset.full", 32'(full), 32'h0);
        chk("reset.rd", 32'(alu_rd_alias), 32'h0);
        chk("reset.imm", alu_imm, 32'h0);
        chk_nop("reset");
        rst_n = 1'b1;
        tick();

        // Table vectors: dispatch, nothing yet, issue one edge later, then NOP.
        for (int v = 0; v < 6; v++) begin
            set_dsp(vecs[v].op, vecs[v].rd, vecs[v].pc, vecs[v].imm,
                    vecs[v].r1_rdy, vecs[v].r1_val, vecs[v].r1_al,
                    vecs[v].r2_rdy, vecs[v].r2_val, vecs[v].r2_al);
            alu_cdb_valid = vecs[v].acv;
            alu_cdb_alias = vecs[v].aca;
            alu_cdb_val   = vecs[v].acd;
            lsb_cdb_valid = vecs[v].lcv;
            lsb_cdb_alias = vecs[v].lca;
            lsb_cdb_val   = vecs[v].lcd;
            tick();
            idle_inputs();
            chk($sformatf("vec%0d.latency", v), 32'(alu_optype), 32'(NOP));
            tick();
            chk($sformatf("vec%0d.optype", v), 32'(alu_optype), 32'(vecs[v].op));
            chk($sformatf("vec%0d.rd", v), 32'(alu_rd_alias), 32'(vecs[v].rd));
            chk($sformatf("vec%0d.pc", v), alu_pc, vecs[v].pc);
            chk($sformatf("vec%0d.imm", v), alu_imm, vecs[v].imm);
            chk($sformatf("vec%0d.rs1", v), alu_rs1, vecs[v].exp_rs1);
            chk($sformatf("vec%0d.rs2", v), alu_rs2, vecs[v].exp_rs2);
            tick();
            chk($sformatf("vec%0d.after", v), 32'(alu_optype), 32'(NOP));
        end

        // Pending operand woken by the ALU CDB two cycles after dispatch.
        set_dsp(OP_ADD, 4'd1, 32'h180, 32'h0, 1'b0, 32'h0, 4'd7, 1'b1, 32'h20, 4'd0);
        tick();
        idle_inputs();
        chk("wake.wait0", 32'(alu_optype), 32'(NOP));
        tick();
        chk("wake.wait1", 32'(alu_optype), 32'(NOP));
        alu_cdb_valid = 1'b1;
        alu_cdb_alias = 4'd7;
        alu_cdb_val   = 32'h10;
        tick();
        idle_inputs();
        chk("wake.bcast_edge", 32'(alu_optype), 32'(NOP));
        tick();
        chk("wake.optype", 32'(alu_optype), 32'(OP_ADD));
        chk("wake.rs1", alu_rs1, 32'h10);
        chk("wake.rs2", alu_rs2, 32'h20);
        tick();
        chk("wake.once", 32'(alu_optype), 32'(NOP));

        // Fill all 16 entries waiting on alias 9, then a 17th dispatch while full.
        for (int i = 0; i < 16; i++) begin
            set_dsp(OP_XOR, 4'(i), 32'h200 + 32'(4 * i), 32'h0, 1'b0, 32'h0, 4'd9,
                    1'b1, 32'(i), 4'd0);
            tick();
        end
        idle_inputs();
        chk("fill.full", 32'(full), 32'h1);
        set_dsp(OP_ADDI, 4'd15, 32'hDEAD_0000, 32'h1, 1'b1, 32'h3, 4'd0, 1'b1, 32'h4, 4'd0);
        tick();
        idle_inputs();
        chk("fill.full_after17", 32'(full), 32'h1);
        chk("fill.nop_after17", 32'(alu_optype), 32'(NOP));
        alu_cdb_valid = 1'b1;
        alu_cdb_alias = 4'd9;
        alu_cdb_val   = 32'h99;
        tick();
        idle_inputs();
        chk("fill.bcast_nop", 32'(alu_optype), 32'(NOP));
        chk("fill.bcast_full", 32'(full), 32'h1);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("fill%0d.rd", i), 32'(alu_rd_alias), 32'(i));
            chk($sformatf("fill%0d.pc", i), alu_pc, 32'h200 + 32'(4 * i));
            chk($sformatf("fill%0d.rs1", i), alu_rs1, 32'h99);
            chk($sformatf("fill%0d.rs2", i), alu_rs2, 32'(i));
            if (i == 0) chk("fill.full_drop", 32'(full), 32'h0);
        end
        tick();
        chk_nop("fill.drained");

        // Rollback with five busy entries (the last one ready) and a simultaneous dispatch.
        for (int i = 0; i < 4; i++) begin
            set_dsp(OP_SUB, 4'(i + 1), 32'h400 + 32'(4 * i), 32'h0, 1'b0, 32'h0, 4'd3,
                    1'b1, 32'h1, 4'd0);
            tick();
        end
        set_dsp(OP_ADD, 4'd5, 32'h410, 32'h0, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0);
        tick();
        set_dsp(OP_ADD, 4'd6, 32'h414, 32'h0, 1'b1, 32'h5, 4'd0, 1'b1, 32'h6, 4'd0);
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        idle_inputs();
        chk_nop("rb.edge");
        chk("rb.full", 32'(full), 32'h0);
        alu_cdb_valid = 1'b1;
        alu_cdb_alias = 4'd3;
        alu_cdb_val   = 32'h33;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rb.flushed%0d", i), 32'(alu_optype), 32'(NOP));
        end

        // rdy low for three cycles holding a ready entry.
        set_dsp(OP_XOR, 4'd7, 32'h300, 32'h0, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0);
        tick();
        idle_inputs();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d.nop", i), 32'(alu_optype), 32'(NOP));
        end
        rdy = 1'b1;
        tick();
        chk("stall.optype", 32'(alu_optype), 32'(OP_XOR));
        chk("stall.rd", 32'(alu_rd_alias), 32'd7);
        chk("stall.pc", alu_pc, 32'h300);
        tick();
        chk("stall.once", 32'(alu_optype), 32'(NOP));

        // Asynchronous reset while an issue is on the outputs.
        set_dsp(OP_ADDI, 4'd8, 32'h500, 32'h9, 1'b1, 32'h4, 4'd0, 1'b1, 32'h0, 4'd0);
        tick();
        idle_inputs();
        tick();
        chk("areset.pre_rd", 32'(alu_rd_alias), 32'd8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset.optype", 32'(alu_optype), 32'(NOP));
        chk("areset.pc", alu_pc, 32'h0);
        chk("areset.imm", alu_imm, 32'h0);
        rst_n = 1'b1;
        tick();
        chk_nop("areset.after");
        chk("areset.full", 32'(full), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
